// File: rtl/piezo_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : piezo_seq                                                      |
// | Purpose : Programmable note sequencer driving a differential piezo.      |
// |           Plays up to DEPTH {period, duration} entries from an internal  |
// |           table, with a programmable pass count (0 = loop forever).      |
// |           Optional snooze support is enabled by PIEZO_SEQ_SNOOZE_EN.      |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module piezo_seq #(
  parameter int DEPTH        = 8,
  parameter int AW           = $clog2(DEPTH),
  parameter int PER_W        = 15,
  parameter int DUR_W        = 8,
  parameter int CLK_PER_TICK = 500000,
  parameter int REP_W        = 4,
  parameter int SNOOZE_TICKS = 6000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_snooze,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [PER_W-1:0] i_wr_per,
  input  logic [DUR_W-1:0] i_wr_dur,
  input  logic [AW:0]      i_seq_len,
  input  logic [REP_W-1:0] i_rep_cnt,
  output logic             o_piezo,
  output logic             o_piezo_n,
  output logic             o_busy,
  output logic             o_done,
  output logic [AW-1:0]    o_note_idx,
  output logic [3:0]       o_state
);

  localparam int            TW         = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
  localparam logic [TW-1:0] c_tick_max = TW'(CLK_PER_TICK - 1);
  localparam logic [AW:0]   c_depth    = (AW+1)'(DEPTH);

  typedef enum logic [3:0] {
    S_IDLE   = 4'b0001,
    S_LOAD   = 4'b0010,
    S_PLAY   = 4'b0100,
    S_SNOOZE = 4'b1000
  } state_t;

  state_t             r_state;
  logic [PER_W-1:0]   r_tbl_per [DEPTH];
  logic [DUR_W-1:0]   r_tbl_dur [DEPTH];
  logic [AW-1:0]      r_idx;
  logic [AW:0]        r_len;
  logic [REP_W-1:0]   r_reps;
  logic [PER_W-1:0]   r_per_reg;
  logic [DUR_W-1:0]   r_dur_reg;
  logic [TW-1:0]      r_tick_cnt;
  logic [DUR_W-1:0]   r_dur_cnt;
  logic [PER_W-1:0]   r_freq_cnt;
  logic               r_done;

`ifdef PIEZO_SEQ_SNOOZE_EN
  localparam int SW = $clog2(SNOOZE_TICKS + 1);
  logic [SW-1:0]      r_snz_cnt;
  logic [REP_W-1:0]   r_reps_init;
`else
  // Snooze is compiled out; the port stays for pin compatibility.
  logic w_unused_snooze;
  assign w_unused_snooze = i_snooze | (SNOOZE_TICKS < 0);
`endif

  logic [PER_W-1:0] w_ld_per;
  logic [DUR_W-1:0] w_ld_dur;
  logic [AW:0]      w_len;
  logic             w_tick;
  logic [DUR_W-1:0] w_dur_nxt;
  logic [PER_W-1:0] w_freq_nxt;
  logic             w_last_note;
  logic             w_note_end;
  logic             w_tone;

  assign w_ld_per    = r_tbl_per[r_idx];
  assign w_ld_dur    = r_tbl_dur[r_idx];
  assign w_len       = (int'(i_seq_len) > DEPTH) ? c_depth : i_seq_len;
  assign w_tick      = (r_tick_cnt == c_tick_max);
  assign w_dur_nxt   = r_dur_cnt + DUR_W'(1);
  assign w_freq_nxt  = r_freq_cnt + PER_W'(1);
  assign w_last_note = !(((AW+1)'(r_idx) + (AW+1)'(1)) < r_len);
  // A zero-duration entry ends in LOAD; otherwise the note ends on its last tick.
  assign w_note_end  = ((r_state == S_LOAD) && (w_ld_dur == '0)) ||
                       ((r_state == S_PLAY) && w_tick && (w_dur_nxt == r_dur_reg));

  // Note table: reset melody in entries 0..3, writable only while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_tbl_per[i] <= '0;
        r_tbl_dur[i] <= '0;
      end
      r_tbl_per[0] <= PER_W'(16'h7C90);  r_tbl_dur[0] <= DUR_W'(8'h40);
      r_tbl_per[1] <= PER_W'(16'h6EF9);  r_tbl_dur[1] <= DUR_W'(8'h20);
      r_tbl_per[2] <= PER_W'(16'h62E4);  r_tbl_dur[2] <= DUR_W'(8'h10);
      r_tbl_per[3] <= PER_W'(16'h038E);  r_tbl_dur[3] <= DUR_W'(8'h20);
    end else if ((r_state == S_IDLE) && i_wr_en && (int'(i_wr_addr) < DEPTH)) begin
      r_tbl_per[i_wr_addr] <= i_wr_per;
      r_tbl_dur[i_wr_addr] <= i_wr_dur;
    end
  end

  // Sequencer FSM with tick, duration and tone counters; stop overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_len      <= '0;
      r_reps     <= '0;
      r_per_reg  <= '0;
      r_dur_reg  <= '0;
      r_tick_cnt <= '0;
      r_dur_cnt  <= '0;
      r_freq_cnt <= '0;
      r_done     <= 1'b0;
`ifdef PIEZO_SEQ_SNOOZE_EN
      r_snz_cnt   <= '0;
      r_reps_init <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      if (i_stop) begin
        r_state    <= S_IDLE;
        r_tick_cnt <= '0;
        r_dur_cnt  <= '0;
        r_freq_cnt <= '0;
      end
`ifdef PIEZO_SEQ_SNOOZE_EN
      else if (i_snooze && (r_state != S_IDLE)) begin
        // Entering snooze, or restarting the count while already snoozing.
        r_state    <= S_SNOOZE;
        r_tick_cnt <= '0;
        r_snz_cnt  <= '0;
      end
`endif
      else begin
        case (r_state)
          S_IDLE: begin
            if (i_start && (i_seq_len != '0)) begin
              r_state <= S_LOAD;
              r_len   <= w_len;
              r_reps  <= i_rep_cnt;
              r_idx   <= '0;
`ifdef PIEZO_SEQ_SNOOZE_EN
              r_reps_init <= i_rep_cnt;
`endif
            end
          end
          S_LOAD: begin
            r_per_reg  <= w_ld_per;
            r_dur_reg  <= w_ld_dur;
            r_tick_cnt <= '0;
            r_dur_cnt  <= '0;
            r_freq_cnt <= '0;
            if (w_ld_dur != '0) r_state <= S_PLAY;
          end
          S_PLAY: begin
            if (w_tick) begin
              r_tick_cnt <= '0;
              r_dur_cnt  <= w_dur_nxt;
            end else begin
              r_tick_cnt <= r_tick_cnt + TW'(1);
            end
            r_freq_cnt <= (w_freq_nxt >= r_per_reg) ? '0 : w_freq_nxt;
          end
`ifdef PIEZO_SEQ_SNOOZE_EN
          S_SNOOZE: begin
            if (w_tick) begin
              r_tick_cnt <= '0;
              if (r_snz_cnt == SW'(SNOOZE_TICKS - 1)) begin
                r_idx   <= '0;
                r_reps  <= r_reps_init;
                r_state <= S_LOAD;
              end else begin
                r_snz_cnt <= r_snz_cnt + SW'(1);
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + TW'(1);
            end
          end
`endif
          default: r_state <= S_IDLE;
        endcase

        if (w_note_end) begin
          if (!w_last_note) begin
            r_idx   <= r_idx + AW'(1);
            r_state <= S_LOAD;
          end else if (r_reps == REP_W'(1)) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end else begin
            if (r_reps != '0) r_reps <= r_reps - REP_W'(1);
            r_idx   <= '0;
            r_state <= S_LOAD;
          end
        end
      end
    end
  end

  // Square wave: high for the first half of each period; rests and
  // non-PLAY states hold both pins low.
  assign w_tone     = (r_state == S_PLAY) && (r_per_reg != '0) && (r_freq_cnt < (r_per_reg >> 1));
  assign o_piezo    = w_tone;
  assign o_piezo_n  = (r_state == S_PLAY) && (r_per_reg != '0) && !w_tone;
  assign o_busy     = (r_state != S_IDLE);
  assign o_done     = r_done;
  assign o_note_idx = r_idx;
  assign o_state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_piezo_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_piezo_seq                                                   |
// | Purpose : Self-checking bench for piezo_seq. A cycle timeline is built   |
// |           from the note table model and compared against the DUT.        |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_piezo_seq;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int PER_W = 15;
  localparam int DUR_W = 8;
  localparam int CPT   = 10;
  localparam int REP_W = 4;
  localparam int SNZ   = 3;

  localparam logic [3:0] ST_IDLE = 4'b0001;
  localparam logic [3:0] ST_LOAD = 4'b0010;
  localparam logic [3:0] ST_PLAY = 4'b0100;
  localparam logic [3:0] ST_SNZ  = 4'b1000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0, stop = 1'b0, snooze = 1'b0, wr_en = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [PER_W-1:0] wr_per = '0;
  logic [DUR_W-1:0] wr_dur = '0;
  logic [AW:0]      seq_len = '0;
  logic [REP_W-1:0] rep_cnt = '0;
  logic             piezo, piezo_n, busy, done;
  logic [AW-1:0]    note_idx;
  logic [3:0]       state;

  always #5 clk = ~clk;

  piezo_seq #(
    .DEPTH(DEPTH), .PER_W(PER_W), .DUR_W(DUR_W), .CLK_PER_TICK(CPT),
    .REP_W(REP_W), .SNOOZE_TICKS(SNZ)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_stop(stop), .i_snooze(snooze),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_per(wr_per), .i_wr_dur(wr_dur),
    .i_seq_len(seq_len), .i_rep_cnt(rep_cnt),
    .o_piezo(piezo), .o_piezo_n(piezo_n), .o_busy(busy), .o_done(done),
    .o_note_idx(note_idx), .o_state(state)
  );

  typedef struct {
    logic [3:0] st;
    int         idx;
    logic       pz;
    logic       pzn;
    logic       dn;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  int   m_per [DEPTH];
  int   m_dur [DEPTH];
  int   last_idx = 0;
  exp_t q [$];

  task automatic chk(input string tag, input exp_t e);
    logic [10:0] obs, expv;
    obs  = {state, note_idx, piezo, piezo_n, busy, done};
    expv = {e.st, 3'(e.idx), e.pz, e.pzn, (e.st != ST_IDLE), e.dn};
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s t=%0t observed{st,idx,pz,pzn,busy,done}=%h expected=%h", tag, $time, obs, expv);
    end
  endtask

  // Expected per-cycle behaviour: each note is one LOAD cycle followed by
  // dur*CPT PLAY cycles; the tone is high for the first half of each period.
  task automatic build(input int len, input int rep);
    int np;
    logic pz;
    np = (rep == 0) ? 2 : rep;
    q.delete();
    for (int p = 0; p < np; p++) begin
      for (int i = 0; i < len; i++) begin
        q.push_back('{ST_LOAD, i, 1'b0, 1'b0, 1'b0});
        for (int k = 0; k < m_dur[i] * CPT; k++) begin
          pz = (m_per[i] != 0) && ((k % m_per[i]) < (m_per[i] / 2));
          q.push_back('{ST_PLAY, i, pz, (m_per[i] != 0) && !pz, 1'b0});
        end
      end
    end
    if (rep != 0) q.push_back('{ST_IDLE, len - 1, 1'b0, 1'b0, 1'b1});
  endtask

  task automatic wr(input int a, input int p, input int d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_per = PER_W'(p); wr_dur = DUR_W'(d);
    m_per[a] = p; m_dur[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Called at a negedge while idle. Starts playback and follows the timeline.
  task automatic play(input string tag, input int slen, input int rep,
                      input int stop_note, input bit wr_mid, input bit do_snz);
    int len, j, seen, sidx;
    bit snz_done;
    len = (slen > DEPTH) ? DEPTH : slen;
    j = 0; seen = 0; snz_done = 1'b0;
    build(len, rep);
    seq_len = (AW+1)'(slen); rep_cnt = REP_W'(rep); start = 1'b1;
    while (j < q.size()) begin
      @(negedge clk);
      start = 1'b0; wr_en = 1'b0; snooze = 1'b0;
      chk(tag, q[j]);
      last_idx = q[j].idx;
      if (j >= 1 && q[j].st != ST_IDLE) begin
        // Mid-play changes to the start-time inputs must be ignored.
        seq_len = (AW+1)'($urandom_range(0, 15));
        rep_cnt = REP_W'($urandom_range(0, 15));
        if (j == 1) start = 1'b1;
      end
      if (wr_mid && j == 3 && q[j].st != ST_IDLE) begin
        wr_en = 1'b1; wr_addr = '0; wr_per = PER_W'(3); wr_dur = DUR_W'(1);
      end
      if (stop_note >= 0 && q[j].st == ST_PLAY && q[j].idx == stop_note) begin
        seen++;
        if (seen == 3) begin
          stop = 1'b1;
          @(negedge clk);
          stop = 1'b0;
          chk({tag, "_stop"}, '{ST_IDLE, last_idx, 1'b0, 1'b0, 1'b0});
          @(negedge clk);
          chk({tag, "_stop2"}, '{ST_IDLE, last_idx, 1'b0, 1'b0, 1'b0});
          return;
        end
      end
      if (do_snz && !snz_done && j == q.size() - 3 && q[j].st != ST_IDLE) begin
        snz_done = 1'b1;
        snooze = 1'b1;
        sidx = q[j].idx;
`ifdef PIEZO_SEQ_SNOOZE_EN
        for (int k = 0; k < SNZ * CPT; k++) begin
          @(negedge clk);
          snooze = 1'b0; start = 1'b0;
          chk({tag, "_snz"}, '{ST_SNZ, sidx, 1'b0, 1'b0, 1'b0});
        end
        build(len, rep);
        j = 0;
        continue;
`endif
      end
      j++;
    end
    @(negedge clk);
    chk({tag, "_idle"}, '{ST_IDLE, last_idx, 1'b0, 1'b0, 1'b0});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin m_per[i] = 0; m_dur[i] = 0; end
    m_per[0] = 'h7C90; m_dur[0] = 'h40;
    m_per[1] = 'h6EF9; m_dur[1] = 'h20;
    m_per[2] = 'h62E4; m_dur[2] = 'h10;
    m_per[3] = 'h038E; m_dur[3] = 'h20;

    repeat (2) @(negedge clk);
    chk("reset", '{ST_IDLE, 0, 1'b0, 1'b0, 1'b0});
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_rel", '{ST_IDLE, 0, 1'b0, 1'b0, 1'b0});

    play("dflt", 4, 1, -1, 1'b0, 1'b0);

    wr(5, 8, 3);
    play("e5", 6, 2, -1, 1'b0, 1'b0);

    wr(1, 'h1234, 0);
    play("skip", 3, 1, -1, 1'b0, 1'b0);

    wr(2, 0, 2);
    play("rest", 3, 1, -1, 1'b0, 1'b0);

    wr(2, 12, 3);
    play("stop", 4, 0, 2, 1'b1, 1'b0);
    play("rdbk", 1, 1, -1, 1'b0, 1'b0);

    // start with seq_len == 0 is ignored
    seq_len = '0; rep_cnt = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("len0", '{ST_IDLE, last_idx, 1'b0, 1'b0, 1'b0});
    // stop wins over start in the same idle cycle
    seq_len = 4'd3; start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("stop_start", '{ST_IDLE, last_idx, 1'b0, 1'b0, 1'b0});

    for (int it = 0; it < 6; it++) begin
      for (int a = 0; a < DEPTH; a++) wr(a, $urandom_range(0, 20), $urandom_range(0, 3));
      play("rnd", $urandom_range(1, 15), $urandom_range(1, 3), -1, 1'b0, 1'b0);
    end

    for (int a = 0; a < DEPTH; a++) wr(a, $urandom_range(2, 12), $urandom_range(1, 2));
    play("snz", 3, 2, -1, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
